// File: rtl/rs_issue_queue_pkg.sv
// Shared parameters, FU encoding and uop payload structs for the unified
// reservation station (dispatch-side Disp_uOP and issue-side Sel_uOP).
package rs_issue_queue_pkg;

  localparam int unsigned RS_ENTRIES = 8;
  localparam int unsigned NUM_FUS    = 4;
  localparam int unsigned NUM_PREGS  = 64;
  localparam int unsigned NUM_CDB    = 2;
  localparam int unsigned PREG_W     = $clog2(NUM_PREGS);
  localparam int unsigned RS_IDX_W   = $clog2(RS_ENTRIES);
  localparam int unsigned OCC_W      = $clog2(RS_ENTRIES + 1);
  localparam int unsigned FU_W       = $clog2(NUM_FUS);
  localparam int unsigned PAYLOAD_W  = 16;

  typedef enum logic [FU_W-1:0] {
    FU_ALU0,
    FU_ALU1,
    FU_MUL,
    FU_LSU
  } fu_type_e;

  typedef struct packed {
    fu_type_e              fu_type;
    logic [PREG_W-1:0]     src1_tag;
    logic                  src1_rdy;
    logic [PREG_W-1:0]     src2_tag;
    logic                  src2_rdy;
    logic [PREG_W-1:0]     dst_tag;
    logic [PAYLOAD_W-1:0]  payload;
  } disp_uop_t;

  typedef struct packed {
    fu_type_e              fu_type;
    logic [PREG_W-1:0]     src1_tag;
    logic [PREG_W-1:0]     src2_tag;
    logic [PREG_W-1:0]     dst_tag;
    logic [PAYLOAD_W-1:0]  payload;
    logic [RS_IDX_W-1:0]   rs_idx;
  } sel_uop_t;

  // True when any valid CDB port broadcasts the given tag.
  function automatic logic cdb_hit(input logic [NUM_CDB-1:0]             vld,
                                   input logic [NUM_CDB-1:0][PREG_W-1:0] tags,
                                   input logic [PREG_W-1:0]              tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      hit |= vld[k] && (tags[k] == tag);
    end
    return hit;
  endfunction

endpackage

// File: rtl/rs_issue_queue_age.sv
// rs_age_matrix: RS_ENTRIES x RS_ENTRIES relative-age matrix with oldest pick.
// Ports: clk, rst (sync, active-high); alloc (one-hot slot being written, made
// youngest); free (slots leaving, row/column cleared); req (candidates);
// grant (one-hot oldest requester, combinational).
module rs_age_matrix
  import rs_issue_queue_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RS_ENTRIES-1:0] alloc,
  input  logic [RS_ENTRIES-1:0] free,
  input  logic [RS_ENTRIES-1:0] req,
  output logic [RS_ENTRIES-1:0] grant
);

  // older_q[i][j] = 1 means entry i is older than entry j
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q, older_d;
  logic [RS_ENTRIES-1:0]                 blocked;

  // Stale bits in rows of empty slots are harmless: a row is cleared on alloc.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      for (int j = 0; j < int'(RS_ENTRIES); j++) begin
        if (i == j || free[i] || free[j] || alloc[i]) begin
          older_d[i][j] = 1'b0;
        end else if (alloc[j]) begin
          older_d[i][j] = 1'b1;
        end
      end
    end
  end

  // An entry wins when no older entry is also requesting.
  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      for (int j = 0; j < int'(RS_ENTRIES); j++) begin
        blocked[i] |= req[j] && older_q[j][i];
      end
      grant[i] = req[i] && !blocked[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: unified reservation station. Takes one uop per cycle from
// dispatch, wakes sources from CDB tag broadcasts and issues the oldest ready
// uop whose FU is free.
// Ports: clk, rst (sync, active-high), flush; disp_valid/disp_ready/disp_uop
// (dispatch handshake); cdb_valid/cdb_tag (wakeup broadcasts); fu_ready (per-FU
// availability); sel_valid/sel_ready/sel_uop (issue handshake); occupancy.
module rs_issue_queue
  import rs_issue_queue_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  disp_uop_t                     disp_uop,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB-1:0][PREG_W-1:0] cdb_tag,
  input  logic [NUM_FUS-1:0]            fu_ready,
  output logic                          sel_valid,
  input  logic                          sel_ready,
  output sel_uop_t                      sel_uop,
  output logic [OCC_W-1:0]              occupancy
);

  disp_uop_t [RS_ENTRIES-1:0] entry_q, entry_d;
  logic [RS_ENTRIES-1:0]      valid_q, valid_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [RS_ENTRIES-1:0]      alloc_oh, free_oh, eligible, grant;
  logic [RS_IDX_W-1:0]        alloc_idx;
  logic                       disp_fire, issue_fire;

  // Readiness uses registered occupancy only, so an issue-freed slot waits a cycle.
  assign disp_ready = (occ_q < OCC_W'(RS_ENTRIES));
  assign occupancy  = occ_q;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = sel_valid && sel_ready && !flush;

  // Lowest-index free slot.
  always_comb begin
    alloc_idx = '0;
    alloc_oh  = '0;
    for (int i = int'(RS_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = RS_IDX_W'(i);
    end
    if (disp_fire) alloc_oh[alloc_idx] = 1'b1;
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      eligible[i] = valid_q[i] && entry_q[i].src1_rdy && entry_q[i].src2_rdy &&
                    fu_ready[entry_q[i].fu_type];
    end
  end

  assign free_oh = flush ? '1 : (issue_fire ? grant : '0);

  rs_age_matrix u_age (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc_oh),
    .free  (free_oh),
    .req   (eligible),
    .grant (grant)
  );

  // Issue mux; grant is all-zero when nothing is eligible, so sel_uop reads 0.
  always_comb begin
    sel_valid = |eligible;
    sel_uop   = '0;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      if (grant[i]) begin
        sel_uop.fu_type  = entry_q[i].fu_type;
        sel_uop.src1_tag = entry_q[i].src1_tag;
        sel_uop.src2_tag = entry_q[i].src2_tag;
        sel_uop.dst_tag  = entry_q[i].dst_tag;
        sel_uop.payload  = entry_q[i].payload;
        sel_uop.rs_idx   = RS_IDX_W'(i);
      end
    end
  end

  // Wakeup, issue invalidation, dispatch write (with CDB bypass), flush last.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    for (int i = 0; i < int'(RS_ENTRIES); i++) begin
      if (cdb_hit(cdb_valid, cdb_tag, entry_q[i].src1_tag)) entry_d[i].src1_rdy = 1'b1;
      if (cdb_hit(cdb_valid, cdb_tag, entry_q[i].src2_tag)) entry_d[i].src2_rdy = 1'b1;
    end
    if (issue_fire) valid_d = valid_d & ~grant;
    if (disp_fire) begin
      entry_d[alloc_idx]          = disp_uop;
      entry_d[alloc_idx].src1_rdy = disp_uop.src1_rdy || cdb_hit(cdb_valid, cdb_tag, disp_uop.src1_tag);
      entry_d[alloc_idx].src2_rdy = disp_uop.src2_rdy || cdb_hit(cdb_valid, cdb_tag, disp_uop.src2_tag);
      valid_d[alloc_idx]          = 1'b1;
    end
    case ({disp_fire, issue_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  a_fu_type_legal : assert property (@(posedge clk) disable iff (rst)
    disp_valid |-> (32'(disp_uop.fu_type) < NUM_FUS))
    else $error("rs_issue_queue: illegal fu_type %0d", disp_uop.fu_type);

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue: expected Sel_uOPs are queued when
// stimulus is driven and compared when the DUT issues.
module tb_rs_issue_queue;
  import rs_issue_queue_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           flush;
  logic                           disp_valid;
  logic                           disp_ready;
  disp_uop_t                      disp_uop;
  logic [NUM_CDB-1:0]             cdb_valid;
  logic [NUM_CDB-1:0][PREG_W-1:0] cdb_tag;
  logic [NUM_FUS-1:0]             fu_ready;
  logic                           sel_valid;
  logic                           sel_ready;
  sel_uop_t                       sel_uop;
  logic [OCC_W-1:0]               occupancy;

  int       n_checks = 0;
  int       n_errors = 0;
  sel_uop_t exp_q[$];
  sel_uop_t mon_exp;

  always #5 clk = ~clk;

  rs_issue_queue dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_uop   (disp_uop),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .fu_ready   (fu_ready),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_uop    (sel_uop),
    .occupancy  (occupancy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic disp_uop_t mk(input logic [1:0] fu, input int s1, input logic r1,
                                   input int s2, input logic r2, input int dst, input int pl);
    disp_uop_t u;
    u.fu_type  = fu_type_e'(fu);
    u.src1_tag = PREG_W'(s1);
    u.src1_rdy = r1;
    u.src2_tag = PREG_W'(s2);
    u.src2_rdy = r2;
    u.dst_tag  = PREG_W'(dst);
    u.payload  = PAYLOAD_W'(pl);
    return u;
  endfunction

  function automatic sel_uop_t exp_of(input disp_uop_t u, input int idx);
    sel_uop_t s;
    s.fu_type  = u.fu_type;
    s.src1_tag = u.src1_tag;
    s.src2_tag = u.src2_tag;
    s.dst_tag  = u.dst_tag;
    s.payload  = u.payload;
    s.rs_idx   = RS_IDX_W'(idx);
    return s;
  endfunction

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 40) begin
      step();
      c++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard: every accepted issue must match the next expected uop.
  always @(negedge clk) begin
    if (!rst && !flush && sel_valid && sel_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_issue", 64'(exp_q.size()), 64'(1));
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("issue_uop", 64'(sel_uop), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    disp_uop_t a, b, c, d, f, g;
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_uop = '0;
    cdb_valid = '0; cdb_tag = '0; fu_ready = 4'hF; sel_ready = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    check_eq("rst_occ", 64'(occupancy), 64'(0));
    check_eq("rst_disp_ready", 64'(disp_ready), 64'(1));
    check_eq("rst_sel_valid", 64'(sel_valid), 64'(0));
    check_eq("rst_sel_uop", 64'(sel_uop), 64'(0));

    // Fill all slots, then drain in dispatch order.
    for (int i = 0; i < 8; i++) begin
      a = mk(2'(i % 4), i, 1'b1, i + 1, 1'b1, 10 + i, 'hA000 + i);
      disp_valid = 1'b1; disp_uop = a;
      exp_q.push_back(exp_of(a, i));
      step();
    end
    disp_valid = 1'b0; #1;
    check_eq("t1_occ_full", 64'(occupancy), 64'(8));
    check_eq("t1_disp_ready", 64'(disp_ready), 64'(0));
    check_eq("t1_sel_valid", 64'(sel_valid), 64'(1));
    sel_ready = 1'b1;
    wait_drain("t1_drain");
    check_eq("t1_occ_empty", 64'(occupancy), 64'(0));
    check_eq("t1_disp_ready_back", 64'(disp_ready), 64'(1));

    // Younger ready uop bypasses an older waiting one; wakeup-to-issue is 1 cycle.
    a = mk(2'd0, 5, 1'b0, 6, 1'b1, 20, 'hB001);
    disp_valid = 1'b1; disp_uop = a; step();
    b = mk(2'd1, 7, 1'b1, 8, 1'b1, 21, 'hB002);
    disp_uop = b; exp_q.push_back(exp_of(b, 1)); step();
    disp_valid = 1'b0; #1;
    check_eq("t2_b_first_valid", 64'(sel_valid), 64'(1));
    check_eq("t2_b_first_idx", 64'(sel_uop.rs_idx), 64'(1));
    step();
    check_eq("t2_a_waits", 64'(sel_valid), 64'(0));
    cdb_valid = 2'b01; cdb_tag[0] = PREG_W'(5);
    exp_q.push_back(exp_of(a, 0)); #1;
    check_eq("t2_no_spec_wake", 64'(sel_valid), 64'(0));
    step(); cdb_valid = '0; #1;
    check_eq("t2_wake_valid", 64'(sel_valid), 64'(1));
    check_eq("t2_wake_idx", 64'(sel_uop.rs_idx), 64'(0));
    step();
    check_eq("t2_occ", 64'(occupancy), 64'(0));

    // Dispatch bypass from CDB port 1, then dual-source wake on two ports.
    c = mk(2'd3, 1, 1'b1, 9, 1'b0, 22, 'hC001);
    disp_valid = 1'b1; disp_uop = c;
    cdb_valid = 2'b10; cdb_tag[1] = PREG_W'(9); cdb_tag[0] = '0;
    exp_q.push_back(exp_of(c, 0)); step();
    disp_valid = 1'b0; cdb_valid = '0; #1;
    check_eq("t3_bypass", 64'(sel_valid), 64'(1));
    step();
    d = mk(2'd0, 11, 1'b0, 12, 1'b0, 23, 'hC002);
    disp_valid = 1'b1; disp_uop = d; step();
    disp_valid = 1'b0;
    cdb_valid = 2'b11; cdb_tag[0] = PREG_W'(11); cdb_tag[1] = PREG_W'(12);
    exp_q.push_back(exp_of(d, 0)); #1;
    check_eq("t3_dual_pending", 64'(sel_valid), 64'(0));
    step(); cdb_valid = '0; #1;
    check_eq("t3_dual_wake", 64'(sel_valid), 64'(1));
    step();

    // Busy FU blocks issue; older uop goes first once it frees.
    fu_ready = 4'b1011;
    a = mk(2'd2, 1, 1'b1, 2, 1'b1, 24, 'hD001);
    b = mk(2'd2, 3, 1'b1, 4, 1'b1, 25, 'hD002);
    disp_valid = 1'b1; disp_uop = a; exp_q.push_back(exp_of(a, 0)); step();
    disp_uop = b; exp_q.push_back(exp_of(b, 1)); step();
    disp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_fu_busy", 64'(sel_valid), 64'(0));
      step();
    end
    fu_ready = 4'hF; #1;
    check_eq("t4_fu_free", 64'(sel_valid), 64'(1));
    check_eq("t4_older_idx", 64'(sel_uop.rs_idx), 64'(0));
    wait_drain("t4_drain");

    // Full queue: issue frees a slot that is not refilled in the same cycle.
    sel_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = mk(2'(i % 4), 30 + i, 1'b1, 31 + i, 1'b1, 40 + i, 'hE000 + i);
      disp_valid = 1'b1; disp_uop = a;
      exp_q.push_back(exp_of(a, i));
      step();
    end
    f = mk(2'd1, 50, 1'b1, 51, 1'b1, 52, 'hF001);
    sel_ready = 1'b1; disp_uop = f; #1;
    check_eq("t5_full_disp_ready", 64'(disp_ready), 64'(0));
    check_eq("t5_full_occ", 64'(occupancy), 64'(8));
    step();
    check_eq("t5_after_issue_occ", 64'(occupancy), 64'(7));
    check_eq("t5_ready_again", 64'(disp_ready), 64'(1));
    exp_q.push_back(exp_of(f, 0)); step();
    disp_valid = 1'b0; #1;
    check_eq("t5_disp_issue_occ", 64'(occupancy), 64'(7));
    wait_drain("t5_drain");
    check_eq("t5_occ_empty", 64'(occupancy), 64'(0));

    // Flush drops all entries and the same-cycle dispatch.
    sel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp_valid = 1'b1; disp_uop = mk(2'd0, 1, 1'b1, 2, 1'b1, i, 'h1000 + i);
      step();
    end
    check_eq("t6_occ5", 64'(occupancy), 64'(5));
    flush = 1'b1; sel_ready = 1'b1; disp_uop = mk(2'd1, 1, 1'b1, 2, 1'b1, 60, 'h2000);
    step();
    flush = 1'b0; disp_valid = 1'b0; #1;
    check_eq("t6_flush_occ", 64'(occupancy), 64'(0));
    check_eq("t6_flush_sel_valid", 64'(sel_valid), 64'(0));
    check_eq("t6_flush_disp_ready", 64'(disp_ready), 64'(1));
    g = mk(2'd3, 3, 1'b1, 4, 1'b1, 61, 'h3000);
    disp_valid = 1'b1; disp_uop = g; exp_q.push_back(exp_of(g, 0)); step();
    disp_valid = 1'b0;
    wait_drain("t6_post_flush");

    // Reset in the middle of traffic.
    sel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp_valid = 1'b1; disp_uop = mk(2'd1, 1, 1'b1, 2, 1'b1, i, 'h4000 + i);
      step();
    end
    rst = 1'b1; sel_ready = 1'b1; step();
    rst = 1'b0; disp_valid = 1'b0; #1;
    check_eq("t7_rst_occ", 64'(occupancy), 64'(0));
    check_eq("t7_rst_sel_valid", 64'(sel_valid), 64'(0));
    check_eq("t7_rst_disp_ready", 64'(disp_ready), 64'(1));
    step(); step(); step();

    check_eq("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
